seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle RV32M divide unit that replaces the single-cycle combinational divide path for DIV/DIVU/REM/REMU.
- The decode/execute stage issues a divide request with a start pulse. The block then runs a radix-2 restoring division, one quotient bit per cycle, and returns a result with a one-cycle valid pulse.
- Sits beside the ALU. The stall logic holds the pipeline while o_busy is high.

Parameters:
- DATA_W, 32, operand/result width (only 32 is verified).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_start  input  1  request strobe; accepted only in IDLE.
- i_flush  input  1  abort any in-flight operation (pipeline flush).
- i_alu_op  input  5  operation code: 01111 DIV, 10000 DIVU, 10001 REM, 10010 REMU.
- i_operand_a  input  DATA_W  dividend.
- i_operand_b  input  DATA_W  divisor.
- o_busy  output  1  high from the cycle after acceptance until the result is delivered.
- o_valid  output  1  one-cycle pulse; o_div_data is valid in that cycle.
- o_div_data  output  DATA_W  quotient or remainder; held stable until the next accepted start.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; o_busy=0, o_valid=0, o_div_data=0.
  - Internal counter and remainder/quotient registers cleared.
  - Reset asserted mid-operation discards the operation with no valid pulse.
- States and transitions:
  - IDLE: i_start=1 with a legal op -> capture operands and op.
    - Signed ops (DIV/REM) capture |a| and |b| and record sign_q = a[31]^b[31] (b nonzero) and sign_r = a[31].
    - Special case detected -> SPECIAL; otherwise -> CALC with counter=DATA_W.
    - An illegal op code with i_start is ignored and the block stays in IDLE.
  - CALC: each cycle, shift {rem,quo} left by 1, trial-subtract the divisor from rem.
    - If the result is non-negative, rem = difference and quo[0] = 1; else quo[0] = 0.
    - Counter decrements each cycle; at 1 -> FIX.
  - FIX: apply signs (two's-complement negate quo if sign_q, rem if sign_r).
    - Select quo for DIV/DIVU, rem for REM/REMU.
    - Register o_div_data -> DONE.
  - SPECIAL: load o_div_data with the RISC-V defined result -> DONE.
    - Divisor=0: quotient = all-ones; remainder = dividend.
    - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
  - DONE: o_valid=1 for exactly this cycle -> IDLE.
- o_busy: 1 in CALC, FIX, SPECIAL, DONE; 0 in IDLE.
- Latency (start-accept edge to the o_valid cycle):
  - Normal: DATA_W+2 = 34 cycles.
  - Special case: 2 cycles.
- i_start while o_busy=1 is ignored; no queuing.
- Back-to-back requests: i_start in the DONE cycle is ignored. A new request is accepted the following cycle (IDLE).
- i_flush:
  - Synchronous; -> IDLE next edge from any state; o_valid forced 0 that cycle; o_div_data keeps its old value.
  - i_flush has priority over i_start in the same cycle.
- Operands and op are registered at acceptance; input changes afterwards have no effect.
- Arithmetic:
  - Remainder datapath is DATA_W+1 bits wide to hold the trial subtraction sign.
  - Unsigned ops never negate.
  - Magnitude of 0x80000000 is handled as unsigned 2^31.

Decomposition:
- Shared package (e.g. alu_pkg) holds the 5-bit op-code localparams (OP_DIV=01111, OP_DIVU=10000, OP_REM=10001, OP_REMU=10010).
- Package also holds a state enum typedef div_state_e {IDLE, CALC, FIX, SPECIAL, DONE}.
- No sub-module is needed; the datapath is a single shift/subtract step. An optional combinational div_step sub-module (one restoring iteration) is allowed.

Test Plan:
- DIVU a=100, b=7, pulse i_start -> o_busy high for 34 cycles; o_valid pulse on cycle 34; o_div_data=14.
- REM a=-100 (0xFFFFFF9C), b=7 -> o_div_data=0xFFFFFFFE (-2). DIV with the same operands -> 0xFFFFFFF2 (-14).
- DIV a=5, b=0 -> valid after 2 cycles, o_div_data=0xFFFFFFFF. REMU a=5, b=0 -> o_div_data=5.
- DIV a=0x80000000, b=0xFFFFFFFF -> o_div_data=0x80000000 after 2 cycles. REM with the same operands -> 0.
- Start DIVU, pulse i_start with different operands at cycle 10, and pulse i_flush at cycle 20:
  - Second start is ignored.
  - After the flush, o_busy=0 next cycle and no o_valid pulse.
  - A fresh DIVU 9/3 then returns 3.
- Assert i_reset low at cycle 15 of a DIV, asynchronously off-edge -> outputs immediately 0, state IDLE; a subsequent request completes normally.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential RV32M divide unit: op codes and FSM states.
package seq_divider_pkg;

    // 5-bit ALU op codes for the divide family
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_DIVU = 5'b10000;
    localparam logic [4:0] OP_REM  = 5'b10001;
    localparam logic [4:0] OP_REMU = 5'b10010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        FIX     = 3'd2,
        SPECIAL = 3'd3,
        DONE    = 3'd4
    } div_state_e;

    // True for any of the four divide/remainder op codes
    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Handshake: i_start is accepted only in IDLE with a legal op; o_busy is high from the
// cycle after acceptance up to and including the o_valid cycle; o_valid is a one-cycle
// pulse qualifying o_div_data, which then holds until a later result overwrites it.
// i_flush aborts any operation on the next edge and wins over i_start.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic [4:0]        i_alu_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic              o_busy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_div_data,
    output div_state_e        o_state
);

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONE = {DATA_W{1'b1}};

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic [4:0]        op_r;
    logic              sign_q;
    logic              sign_r;
    logic              div_zero;
    logic              valid_r;
    logic              busy_r;
    logic [DATA_W-1:0] data_r;

    // Request decode: signedness, magnitudes and special-case detection
    logic              in_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              b_zero;
    logic              in_special;

    assign in_signed  = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    assign a_neg      = in_signed && i_operand_a[DATA_W-1];
    assign b_neg      = in_signed && i_operand_b[DATA_W-1];
    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    assign a_mag      = a_neg ? (~i_operand_a + 1'b1) : i_operand_a;
    assign b_mag      = b_neg ? (~i_operand_b + 1'b1) : i_operand_b;
    assign b_zero     = (i_operand_b == '0);
    assign in_special = b_zero ||
                        (in_signed && (i_operand_a == MIN_NEG) && (i_operand_b == ALL_ONE));

    // One restoring step; the trial difference is DATA_W+1 bits so its MSB is the sign
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            diff_neg;

    assign shifted  = {rem, quo[DATA_W-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign diff_neg = diff[DATA_W];

    // Sign fix-up and result selection
    logic              op_is_rem;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign op_is_rem = (op_r == OP_REM) || (op_r == OP_REMU);
    assign q_fix     = sign_q ? (~quo + 1'b1) : quo;
    assign r_fix     = sign_r ? (~rem + 1'b1) : rem;

    // Control FSM and datapath registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            op_r     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            data_r   <= '0;
        end else begin
            valid_r <= 1'b0;
            if (i_flush) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start && is_div_op(i_alu_op)) begin
                            op_r     <= i_alu_op;
                            busy_r   <= 1'b1;
                            divisor  <= b_mag;
                            rem      <= '0;
                            cnt      <= CNT_W'(DATA_W);
                            sign_q   <= in_signed && !b_zero &&
                                        (i_operand_a[DATA_W-1] ^ i_operand_b[DATA_W-1]);
                            sign_r   <= a_neg;
                            div_zero <= b_zero;
                            if (in_special) begin
                                // keep the raw dividend: it is the REM result for b == 0
                                quo   <= i_operand_a;
                                state <= SPECIAL;
                            end else begin
                                quo   <= a_mag;
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        if (!diff_neg) begin
                            rem <= diff[DATA_W-1:0];
                        end else begin
                            rem <= shifted[DATA_W-1:0];
                        end
                        quo <= {quo[DATA_W-2:0], !diff_neg};
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        data_r  <= op_is_rem ? r_fix : q_fix;
                        valid_r <= 1'b1;
                        state   <= DONE;
                    end
                    SPECIAL: begin
                        if (div_zero) begin
                            data_r <= op_is_rem ? quo : ALL_ONE;
                        end else begin
                            data_r <= op_is_rem ? '0 : MIN_NEG;
                        end
                        valid_r <= 1'b1;
                        state   <= DONE;
                    end
                    DONE: begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy     = busy_r;
    // A flush in the DONE cycle suppresses the pulse in that same cycle
    assign o_valid    = valid_r && !i_flush;
    assign o_div_data = data_r;
    assign o_state    = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vectors with hand-computed results, latency and busy
// length, special cases, flush abort and asynchronous reset mid-operation.
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [4:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        valid;
    logic [31:0] div_data;
    div_state_e  state;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_exp;

    seq_divider #(.DATA_W(32), .CNT_W(6)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_flush     (flush),
        .i_alu_op    (alu_op),
        .i_operand_a (op_a),
        .i_operand_b (op_b),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_div_data  (div_data),
        .o_state     (state)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its valid pulse (bounded wait).
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
        int lat;
        int busy_n;
        bit seen;
        lat = 0;
        busy_n = 0;
        seen = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        @(negedge clk);
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        for (int c = 1; c <= 100 && !seen; c++) begin
            lat = c;
            if (busy) busy_n++;
            if (valid) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq({tag, "_valid"}, 32'(seen), 32'd1);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_len"}, 32'(busy_n), 32'(exp_lat));
        check_eq({tag, "_data"}, div_data, exp_data);
        last_exp = exp_data;
        @(negedge clk);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid_after"}, 32'(valid), 32'd0);
        check_eq({tag, "_hold"}, div_data, exp_data);
    endtask

    initial begin
        int valid_seen;
        n_checks = 0;
        n_errors = 0;
        last_exp = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        alu_op = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", div_data, 32'd0);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;

        // normal and special vectors
        run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         34);
        run_op("rem_m100_7",   OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34);
        run_op("div_m100_7",   OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   34);
        run_op("div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   2);
        run_op("remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'd5,          2);
        run_op("div_ovf",      OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   2);
        run_op("rem_ovf",      OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          2);
        run_op("rem_m100_0",   OP_REM,  32'hFFFFFF9C,   32'd0,          32'hFFFFFF9C,   2);
        run_op("div_7_m2",     OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34);
        run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          34);
        run_op("rem_m7_2",     OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34);
        run_op("div_min_2",    OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   34);
        run_op("divu_min_m1",  OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34);
        run_op("divu_max_1",   OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34);
        run_op("remu_max_16",  OP_REMU, 32'hFFFFFFFF,   32'd16,         32'd15,         34);

        // illegal op code is ignored
        @(negedge clk);
        start  = 1'b1;
        alu_op = 5'b00000;
        op_a   = 32'd10;
        op_b   = 32'd2;
        @(negedge clk);
        start  = 1'b0;
        check_eq("illegal_busy", 32'(busy), 32'd0);
        check_eq("illegal_state", 32'(state), 32'(IDLE));

        // flush test: second start ignored, flush aborts with no pulse
        valid_seen = 0;
        @(negedge clk);
        start  = 1'b1;
        alu_op = OP_DIVU;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (valid) valid_seen++;
            if (c == 10) begin
                start = 1'b1;
                op_a  = 32'd50;
                op_b  = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (c == 20) flush = 1'b1;
            @(negedge clk);
        end
        flush = 1'b0;
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_valid", 32'(valid), 32'd0);
        check_eq("flush_state", 32'(state), 32'(IDLE));
        check_eq("flush_hold", div_data, last_exp);
        for (int c = 0; c < 40; c++) begin
            if (valid) valid_seen++;
            @(negedge clk);
        end
        check_eq("flush_no_pulse", 32'(valid_seen), 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // asynchronous reset mid-operation
        @(negedge clk);
        start  = 1'b1;
        alu_op = OP_DIV;
        op_a   = 32'hFFFFFF9C;
        op_b   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_valid", 32'(valid), 32'd0);
        check_eq("arst_data", div_data, 32'd0);
        check_eq("arst_state", 32'(state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("div_after_rst", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
